// File: rtl/control_sequencer.sv
// control_sequencer
//   Control-step sequencer for the datapath. It runs the fetch phase (T0..T2)
//   and the execute steps of br, jr and jal, plus nop and halt. It also
//   provides run/idle gating, memory wait states with a timeout, a halt
//   state and a counter of retired instructions.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   clr        asynchronous active-high reset
//   run        level; permits starting a new fetch
//   ir         instruction register (opcode is valid from T3)
//   con_ff     branch condition, sampled in T6
//   mem_ready  memory read data is valid this cycle
//   step       0 = idle, 1..7 = T0..T6 (HALT reports 7)
//   pc_out .. link_in   one-cycle datapath strobes
//   halted     high while in HALT
//   bus_fault  sticky; set on a T1 timeout
//   illegal    one-cycle pulse in T3 on an unsupported opcode
//   retired    count of completed instructions, wraps mod 2^CNT_W
module control_sequencer #(
  parameter int unsigned        OPC_W   = 5,
  parameter int unsigned        OPC_LSB = 27,
  parameter int unsigned        IR_W    = 32,
  parameter int unsigned        TIMEOUT = 16,
  parameter int unsigned        CNT_W   = 16,
  parameter logic [OPC_W-1:0]   OP_BR   = 5'b10010,
  parameter logic [OPC_W-1:0]   OP_JR   = 5'b10011,
  parameter logic [OPC_W-1:0]   OP_JAL  = 5'b10100,
  parameter logic [OPC_W-1:0]   OP_NOP  = 5'b11010,
  parameter logic [OPC_W-1:0]   OP_HALT = 5'b11011
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [IR_W-1:0]  ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  output logic [2:0]       step,
  output logic             pc_out,
  output logic             mar_in,
  output logic             inc_pc,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             y_in,
  output logic             c_out,
  output logic             add,
  output logic             link_in,
  output logic             halted,
  output logic             bus_fault,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               fault_q, fault_d;
  logic               jal_q, jal_d;   // T4 belongs to jal (1) or br (0)
  logic               finish;

  logic [OPC_W-1:0]   op;
  logic [IR_W-1:0]    ir_unused;      // only the opcode field is decoded

  assign op        = ir[OPC_LSB +: OPC_W];
  assign ir_unused = ir;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    jal_d     = jal_q;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      S_T1: begin
        // Ready data wins over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_d = S_T2;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        case (op)
          OP_JR:  finish = 1'b1;
          OP_NOP: finish = 1'b1;
          OP_JAL: begin
            state_d = S_T4;
            jal_d   = 1'b1;
          end
          OP_BR: begin
            state_d = S_T4;
            jal_d   = 1'b0;
          end
          OP_HALT: begin
            state_d   = S_HALT;
            retired_d = retired_q + CNT_W'(1);
          end
          // Unsupported opcode ends the instruction without counting it.
          default: state_d = run ? S_T0 : S_IDLE;
        endcase
      end
      S_T4: begin
        if (jal_q) finish  = 1'b1;
        else       state_d = S_T5;
      end
      S_T5: state_d = S_T6;
      S_T6: finish = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = run ? S_T0 : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      jal_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      jal_q     <= jal_d;
    end
  end

  // Outputs are decoded from the registered state so that an asynchronous
  // clr drops them immediately; zlow_out/pc_in in T1, pc_in in T6 and
  // illegal in T3 also look at the current inputs.
  always_comb begin
    step     = 3'd0;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    add      = 1'b0;
    link_in  = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_T0: begin
        step   = 3'd1;
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        step     = 3'd2;
        read     = 1'b1;
        mdr_in   = 1'b1;
        zlow_out = mem_ready;
        pc_in    = mem_ready;
      end
      S_T2: begin
        step    = 3'd3;
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        step = 3'd4;
        case (op)
          OP_JR: begin
            gra   = 1'b1;
            r_out = 1'b1;
            pc_in = 1'b1;
          end
          OP_JAL: begin
            pc_out  = 1'b1;
            link_in = 1'b1;
          end
          OP_BR: begin
            gra    = 1'b1;
            r_out  = 1'b1;
            con_in = 1'b1;
          end
          OP_NOP:  ;
          OP_HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      S_T4: begin
        step = 3'd5;
        if (jal_q) begin
          gra   = 1'b1;
          r_out = 1'b1;
          pc_in = 1'b1;
        end else begin
          pc_out = 1'b1;
          y_in   = 1'b1;
        end
      end
      S_T5: begin
        step  = 3'd6;
        c_out = 1'b1;
        add   = 1'b1;
        z_in  = 1'b1;
      end
      S_T6: begin
        step     = 3'd7;
        zlow_out = 1'b1;
        pc_in    = con_ff;
      end
      S_HALT: begin
        step   = 3'd7;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_fault = fault_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  step;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out;
  logic ir_in, gra, r_out, con_in, y_in, c_out, add, link_in;
  logic        halted, bus_fault, illegal;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;

  always #5 clk = ~clk;

  control_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .con_ff(con_ff),
    .mem_ready(mem_ready), .step(step),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out),
    .con_in(con_in), .y_in(y_in), .c_out(c_out), .add(add),
    .link_in(link_in), .halted(halted), .bus_fault(bus_fault),
    .illegal(illegal), .retired(retired)
  );

  logic [16:0] sb;
  assign sb = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
               mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, add, link_in};

  localparam logic [16:0] B_PC_OUT = 17'h10000, B_MAR_IN = 17'h08000,
                          B_INC_PC = 17'h04000, B_Z_IN   = 17'h02000,
                          B_ZLOW   = 17'h01000, B_PC_IN  = 17'h00800,
                          B_READ   = 17'h00400, B_MDR_IN = 17'h00200,
                          B_MDR_OUT= 17'h00100, B_IR_IN  = 17'h00080,
                          B_GRA    = 17'h00040, B_R_OUT  = 17'h00020,
                          B_CON_IN = 17'h00010, B_Y_IN   = 17'h00008,
                          B_C_OUT  = 17'h00004, B_ADD    = 17'h00002,
                          B_LINK   = 17'h00001;
  localparam logic [16:0] S_T0   = B_PC_OUT | B_MAR_IN | B_INC_PC | B_Z_IN;
  localparam logic [16:0] S_T1W  = B_READ | B_MDR_IN;
  localparam logic [16:0] S_T1R  = B_READ | B_MDR_IN | B_ZLOW | B_PC_IN;
  localparam logic [16:0] S_T2   = B_MDR_OUT | B_IR_IN;
  localparam logic [16:0] S_JR   = B_GRA | B_R_OUT | B_PC_IN;
  localparam logic [16:0] S_JAL3 = B_PC_OUT | B_LINK;
  localparam logic [16:0] S_BR3  = B_GRA | B_R_OUT | B_CON_IN;
  localparam logic [16:0] S_BR4  = B_PC_OUT | B_Y_IN;
  localparam logic [16:0] S_BR5  = B_C_OUT | B_ADD | B_Z_IN;

  localparam logic [31:0] IR_BR   = 32'h9000_0000;
  localparam logic [31:0] IR_JR   = 32'h9800_0000;
  localparam logic [31:0] IR_JAL  = 32'hA000_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_ILL  = 32'h1800_0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks T0..T2 with `waits` not-ready cycles in T1; leaves the bench in T3.
  task automatic fetch(input string tag, input int waits);
    checks++;
    if (step !== 3'd1 || sb !== S_T0) begin
      failures++;
      $display("FAIL %s_T0: step=%0d strobes=%h expected step=1 strobes=%h", tag, step, sb, S_T0);
    end
    tick();
    for (int c = 0; c <= waits; c++) begin
      mem_ready = (c == waits);
      #1;
      checks++;
      if (step !== 3'd2 || sb !== ((c == waits) ? S_T1R : S_T1W)) begin
        failures++;
        $display("FAIL %s_T1[%0d]: step=%0d strobes=%h expected step=2 strobes=%h",
                 tag, c, step, sb, (c == waits) ? S_T1R : S_T1W);
      end
      tick();
    end
    mem_ready = 1'b0;
    checks++;
    if (step !== 3'd3 || sb !== S_T2) begin
      failures++;
      $display("FAIL %s_T2: step=%0d strobes=%h expected step=3 strobes=%h", tag, step, sb, S_T2);
    end
    tick();
  endtask

  task automatic test_reset;
    clr = 1'b1; run = 1'b0;
    repeat (3) tick();
    clr = 1'b0;
    tick();
    checks++;
    if (step !== 3'd0 || sb !== '0 || halted !== 1'b0 || bus_fault !== 1'b0 ||
        illegal !== 1'b0 || retired !== 16'd0) begin
      failures++;
      $display("FAIL reset: step=%0d strobes=%h halted=%b fault=%b illegal=%b retired=%0d expected all zero",
               step, sb, halted, bus_fault, illegal, retired);
    end
    run = 1'b1;
    tick();
    checks++;
    if (step !== 3'd1 || sb !== S_T0) begin
      failures++;
      $display("FAIL reset_to_T0: step=%0d strobes=%h expected step=1 strobes=%h", step, sb, S_T0);
    end
  endtask

  task automatic test_jr;
    ir = IR_JR;
    fetch("jr", 0);
    checks++;
    if (step !== 3'd4 || sb !== S_JR || illegal !== 1'b0) begin
      failures++;
      $display("FAIL jr_T3: step=%0d strobes=%h illegal=%b expected step=4 strobes=%h illegal=0",
               step, sb, illegal, S_JR);
    end
    tick();
    exp_ret++;
    checks++;
    if (step !== 3'd1 || retired !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL jr_next: step=%0d retired=%0d expected step=1 retired=%0d", step, retired, exp_ret);
    end
  endtask

  task automatic test_br(input logic con, input logic drop_run);
    ir = IR_BR;
    con_ff = ~con;
    if (drop_run) run = 1'b0;
    fetch("br", 0);
    checks++;
    if (step !== 3'd4 || sb !== S_BR3) begin
      failures++;
      $display("FAIL br_T3: step=%0d strobes=%h expected step=4 strobes=%h", step, sb, S_BR3);
    end
    tick();
    checks++;
    if (step !== 3'd5 || sb !== S_BR4) begin
      failures++;
      $display("FAIL br_T4: step=%0d strobes=%h expected step=5 strobes=%h", step, sb, S_BR4);
    end
    tick();
    checks++;
    if (step !== 3'd6 || sb !== S_BR5) begin
      failures++;
      $display("FAIL br_T5: step=%0d strobes=%h expected step=6 strobes=%h", step, sb, S_BR5);
    end
    tick();
    con_ff = con;
    #1;
    checks++;
    if (step !== 3'd7 || sb !== (B_ZLOW | (con ? B_PC_IN : 17'h0))) begin
      failures++;
      $display("FAIL br_T6_con%0b: step=%0d strobes=%h expected step=7 strobes=%h",
               con, step, sb, B_ZLOW | (con ? B_PC_IN : 17'h0));
    end
    tick();
    exp_ret++;
    checks++;
    if (step !== (drop_run ? 3'd0 : 3'd1) || retired !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL br_end: step=%0d retired=%0d expected step=%0d retired=%0d",
               step, retired, drop_run ? 0 : 1, exp_ret);
    end
  endtask

  task automatic test_wait_jal;
    ir = IR_JAL;
    fetch("jal", 3);
    checks++;
    if (step !== 3'd4 || sb !== S_JAL3) begin
      failures++;
      $display("FAIL jal_T3: step=%0d strobes=%h expected step=4 strobes=%h", step, sb, S_JAL3);
    end
    tick();
    checks++;
    if (step !== 3'd5 || sb !== S_JR || bus_fault !== 1'b0) begin
      failures++;
      $display("FAIL jal_T4: step=%0d strobes=%h fault=%b expected step=5 strobes=%h fault=0",
               step, sb, bus_fault, S_JR);
    end
    tick();
    exp_ret++;
    checks++;
    if (step !== 3'd1 || retired !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL jal_next: step=%0d retired=%0d expected step=1 retired=%0d", step, retired, exp_ret);
    end
  endtask

  task automatic test_nop_illegal;
    ir = IR_NOP;
    fetch("nop", 0);
    checks++;
    if (step !== 3'd4 || sb !== '0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL nop_T3: step=%0d strobes=%h illegal=%b expected step=4 strobes=0 illegal=0",
               step, sb, illegal);
    end
    tick();
    exp_ret++;
    ir = IR_ILL;
    fetch("ill", 0);
    checks++;
    if (step !== 3'd4 || sb !== '0 || illegal !== 1'b1) begin
      failures++;
      $display("FAIL ill_T3: step=%0d strobes=%h illegal=%b expected step=4 strobes=0 illegal=1",
               step, sb, illegal);
    end
    tick();
    checks++;
    if (step !== 3'd1 || illegal !== 1'b0 || retired !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL ill_next: step=%0d illegal=%b retired=%0d expected step=1 illegal=0 retired=%0d",
               step, illegal, retired, exp_ret);
    end
  endtask

  task automatic test_run_drop;
    test_br(1'b1, 1'b1);
    tick();
    checks++;
    if (step !== 3'd0 || sb !== '0) begin
      failures++;
      $display("FAIL idle_hold: step=%0d strobes=%h expected step=0 strobes=0", step, sb);
    end
    run = 1'b1;
    tick();
  endtask

  task automatic test_async_reset;
    ir = IR_BR;
    fetch("arst", 0);
    tick();
    tick();
    #2 clr = 1'b1;
    #1;
    exp_ret = 0;
    checks++;
    if (step !== 3'd0 || sb !== '0 || retired !== 16'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL async_clr: step=%0d strobes=%h retired=%0d halted=%b expected all zero",
               step, sb, retired, halted);
    end
    #2 clr = 1'b0;
    tick();
    checks++;
    if (step !== 3'd1 || sb !== S_T0) begin
      failures++;
      $display("FAIL async_T0: step=%0d strobes=%h expected step=1 strobes=%h", step, sb, S_T0);
    end
  endtask

  task automatic test_halt;
    ir = IR_HALT;
    fetch("halt", 0);
    tick();
    exp_ret++;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      checks++;
      if (step !== 3'd7 || halted !== 1'b1 || sb !== '0 || retired !== 16'(exp_ret)) begin
        failures++;
        $display("FAIL halt[%0d]: step=%0d halted=%b strobes=%h retired=%0d expected step=7 halted=1 strobes=0 retired=%0d",
                 i, step, halted, sb, retired, exp_ret);
      end
      tick();
    end
    mem_ready = 1'b0;
    #2 clr = 1'b1;
    #1;
    exp_ret = 0;
    checks++;
    if (halted !== 1'b0 || step !== 3'd0 || retired !== 16'd0) begin
      failures++;
      $display("FAIL halt_clr: halted=%b step=%0d retired=%0d expected 0 0 0", halted, step, retired);
    end
    #2 clr = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    checks++;
    if (step !== 3'd1) begin
      failures++;
      $display("FAIL to_T0: step=%0d expected 1", step);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'b0;
      #1;
      checks++;
      if (step !== 3'd2 || sb !== S_T1W || bus_fault !== 1'b0) begin
        failures++;
        $display("FAIL to_T1[%0d]: step=%0d strobes=%h fault=%b expected step=2 strobes=%h fault=0",
                 c, step, sb, bus_fault, S_T1W);
      end
      tick();
    end
    tick();
    checks++;
    if (step !== 3'd7 || halted !== 1'b1 || bus_fault !== 1'b1 || sb !== '0 || retired !== 16'd0) begin
      failures++;
      $display("FAIL timeout: step=%0d halted=%b fault=%b strobes=%h retired=%0d expected 7 1 1 0 0",
               step, halted, bus_fault, sb, retired);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if (bus_fault !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL fault_clr: fault=%b halted=%b expected 0 0", bus_fault, halted);
    end
    #2 clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jr();
    test_br(1'b0, 1'b0);
    test_br(1'b1, 1'b0);
    test_wait_jal();
    test_nop_illegal();
    test_run_drop();
    test_async_reset();
    test_halt();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
